// File: rtl/packet_serializer_if.sv
// Handshake bundle between the scheduler/selector side and the AXI-facing replay channels.
// The serializer is the master: it drives the header/beat channels and the consumed/busy status.
interface packet_serializer_if #(
  parameter int DATA_SIZE   = 678,
  parameter int HEADER_SIZE = 102,
  parameter int BEATS       = 4,
  parameter int BEAT_SIZE   = 128,
  parameter int STRB_SIZE   = 16
);
  logic [DATA_SIZE-1:0]   packet_in;
  logic                   activate;
  logic                   consumed;
  logic [HEADER_SIZE-1:0] header_out;
  logic                   header_valid;
  logic                   header_ready;
  logic [BEAT_SIZE-1:0]   beat_data;
  logic [STRB_SIZE-1:0]   beat_strb;
  logic                   beat_last;
  logic                   beat_valid;
  logic                   beat_ready;
  logic                   busy;

  modport master (
    input  packet_in, activate, header_ready, beat_ready,
    output consumed, header_out, header_valid, beat_data, beat_strb, beat_last, beat_valid, busy
  );

  modport slave (
    output packet_in, activate, header_ready, beat_ready,
    input  consumed, header_out, header_valid, beat_data, beat_strb, beat_last, beat_valid, busy
  );
endinterface

// File: rtl/packet_serializer.sv
// Captures a scheduled packet and replays it as one header transfer plus, for writes,
// len+1 data beats on valid/ready channels, then pulses consumed back to the scheduler.
//
// state  | meaning
// IDLE   | waiting for activate; captures packet_in when it is seen
// HEADER | header_valid high until header_ready
// DATA   | beat cnt_q presented until beat_ready; last beat when cnt_q == len
// DONE   | consumed pulse for one cycle, back to IDLE
module packet_serializer #(
  parameter int DATA_SIZE   = 678,
  parameter int HEADER_SIZE = 102,
  parameter int BEATS       = 4,
  parameter int BEAT_SIZE   = 128,
  parameter int STRB_SIZE   = 16
) (
  input logic                clock,
  input logic                reset,
  packet_serializer_if.master bus
);

  // BEATS must be at least 2 so that the len field is non-empty
  localparam int CNT_W     = $clog2(BEATS);
  localparam int STRB_BASE = HEADER_SIZE;
  localparam int DATA_BASE = HEADER_SIZE + BEATS * STRB_SIZE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]   buf_q, buf_d;
  logic                   header_valid_q, header_valid_d;
  logic                   beat_valid_q, beat_valid_d;
  logic                   beat_last_q, beat_last_d;
  logic                   consumed_q, consumed_d;
  logic                   busy_q, busy_d;
  logic [BEAT_SIZE-1:0]   beat_data_q, beat_data_d;
  logic [STRB_SIZE-1:0]   beat_strb_q, beat_strb_d;
  logic [CNT_W-1:0]       len;

  assign len = buf_q[CNT_W:1];

  function automatic logic [BEAT_SIZE-1:0] data_of(input logic [DATA_SIZE-1:0] p,
                                                   input logic [CNT_W-1:0] i);
    return p[DATA_BASE + int'(i) * BEAT_SIZE +: BEAT_SIZE];
  endfunction

  function automatic logic [STRB_SIZE-1:0] strb_of(input logic [DATA_SIZE-1:0] p,
                                                   input logic [CNT_W-1:0] i);
    return p[STRB_BASE + int'(i) * STRB_SIZE +: STRB_SIZE];
  endfunction

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    buf_d          = buf_q;
    header_valid_d = header_valid_q;
    beat_valid_d   = beat_valid_q;
    beat_last_d    = beat_last_q;
    consumed_d     = consumed_q;
    busy_d         = busy_q;
    beat_data_d    = beat_data_q;
    beat_strb_d    = beat_strb_q;

    case (state_q)
      IDLE: begin
        if (bus.activate) begin
          buf_d          = bus.packet_in;
          state_d        = HEADER;
          header_valid_d = 1'b1;
          busy_d         = 1'b1;
        end
      end
      HEADER: begin
        if (bus.header_ready) begin
          header_valid_d = 1'b0;
          cnt_d          = '0;
          if (buf_q[0]) begin
            state_d      = DATA;
            beat_valid_d = 1'b1;
            beat_data_d  = data_of(buf_q, '0);
            beat_strb_d  = strb_of(buf_q, '0);
            beat_last_d  = (len == '0);
          end else begin
            state_d      = DONE;
            consumed_d   = 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.beat_ready) begin
          if (cnt_q == len) begin
            state_d      = DONE;
            beat_valid_d = 1'b0;
            beat_last_d  = 1'b0;
            consumed_d   = 1'b1;
          end else begin
            cnt_d        = cnt_q + CNT_W'(1);
            beat_data_d  = data_of(buf_q, cnt_d);
            beat_strb_d  = strb_of(buf_q, cnt_d);
            beat_last_d  = (cnt_d == len);
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        consumed_d = 1'b0;
        busy_d     = 1'b0;
        cnt_d      = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      buf_q          <= '0;
      header_valid_q <= 1'b0;
      beat_valid_q   <= 1'b0;
      beat_last_q    <= 1'b0;
      consumed_q     <= 1'b0;
      busy_q         <= 1'b0;
      beat_data_q    <= '0;
      beat_strb_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      buf_q          <= buf_d;
      header_valid_q <= header_valid_d;
      beat_valid_q   <= beat_valid_d;
      beat_last_q    <= beat_last_d;
      consumed_q     <= consumed_d;
      busy_q         <= busy_d;
      beat_data_q    <= beat_data_d;
      beat_strb_q    <= beat_strb_d;
    end
  end

  // header_out is the captured buffer itself, so it holds until the next capture
  assign bus.header_out   = buf_q[HEADER_SIZE-1:0];
  assign bus.header_valid = header_valid_q;
  assign bus.beat_valid   = beat_valid_q;
  assign bus.beat_last    = beat_last_q;
  assign bus.beat_data    = beat_data_q;
  assign bus.beat_strb    = beat_strb_q;
  assign bus.consumed     = consumed_q;
  assign bus.busy         = busy_q;

endmodule
